// File: rtl/zf_pkg.sv
// Shared types, widths and lane helpers for the zero-forcing back-substitution datapath.
// Elements are signed Q4.12 fixed point, two lanes packed per bus word.
package zf_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FRAC_W = 12;
    localparam int unsigned BUS_W  = 2 * DATA_W;

    localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

    typedef logic signed [DATA_W-1:0] elem_t;
    typedef logic signed [BUS_W-1:0]  prod_t;
    typedef logic        [BUS_W-1:0]  bus_t;

    // Lane 1 sits in the upper half of the bus word, lane 0 in the lower half.
    function automatic elem_t lane_get(input bus_t w, input int unsigned idx);
        return elem_t'(w[idx*DATA_W +: DATA_W]);
    endfunction

    function automatic bus_t lane_pack(input elem_t l1, input elem_t l0);
        return {l1, l0};
    endfunction

endpackage

// File: rtl/midprocess_zf_if.sv
// Operand/result bus of the back-substitution middle stage.
// The slave modport is the detector stage; the master modport is the upstream driver.
interface midprocess_zf_if;
    import zf_pkg::*;

    logic accept_in;
    logic ready_out;
    logic accept_out;
    bus_t Q_processed_2;
    bus_t R;
    bus_t X_pre;
    bus_t X_mid_pre;

    modport master (
        output accept_in,
        output Q_processed_2,
        output R,
        output X_pre,
        input  ready_out,
        input  accept_out,
        input  X_mid_pre
    );

    modport slave (
        input  accept_in,
        input  Q_processed_2,
        input  R,
        input  X_pre,
        output ready_out,
        output accept_out,
        output X_mid_pre
    );

endinterface

// File: rtl/zf_mul_sub_lane.sv
// One lane of Q - (R*X >>> FRAC_W) with saturation, split into its product half
// (feeding stage 1) and its subtract/saturate half (feeding stage 2). Purely combinational.
module zf_mul_sub_lane
    import zf_pkg::*;
(
    input  elem_t r_i,
    input  elem_t x_i,
    output prod_t p_o,
    input  elem_t q_i,
    input  prod_t p_i,
    output elem_t d_o
);

    localparam int unsigned DIFF_W = BUS_W + 1;

    localparam logic signed [DIFF_W-1:0] DIFF_MAX = {{(DIFF_W-DATA_W){1'b0}}, SAT_MAX};
    localparam logic signed [DIFF_W-1:0] DIFF_MIN = {{(DIFF_W-DATA_W){1'b1}}, SAT_MIN};

    prod_t prod;
    logic signed [DIFF_W-1:0] diff;

    assign prod = prod_t'(r_i) * prod_t'(x_i);
    assign p_o  = prod >>> FRAC_W;

    // The shifted product can reach 2^18, so the difference is kept wide enough that
    // saturation sees the true value instead of a wrapped one.
    assign diff = {{(DIFF_W-DATA_W){q_i[DATA_W-1]}}, q_i} - {p_i[BUS_W-1], p_i};

    always_comb begin
        d_o = diff[DATA_W-1:0];
        if (diff > DIFF_MAX) begin
            d_o = SAT_MAX;
        end else if (diff < DIFF_MIN) begin
            d_o = SAT_MIN;
        end
    end

endmodule

// File: rtl/midprocess_zf.sv
// Middle stage of the 2x2 MIMO zero-forcing back-substitution: two-stage pipeline computing
// saturate(Q - R*X) per lane, with a global enable that freezes every stage.
module midprocess_zf
    import zf_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    midprocess_zf_if.slave  bus
);

    logic  ready_q;
    logic  v1_q;
    logic  v2_q;
    bus_t  q1_q;
    prod_t p1_q [2];
    bus_t  x_mid_q;

    prod_t p_new [2];
    elem_t d_lane [2];
    logic  xfer;

    assign xfer = enable & bus.accept_in & ready_q;

    for (genvar i = 0; i < 2; i++) begin : g_lane
        zf_mul_sub_lane u_lane (
            .r_i (lane_get(bus.R, i)),
            .x_i (lane_get(bus.X_pre, i)),
            .p_o (p_new[i]),
            .q_i (lane_get(q1_q, i)),
            .p_i (p1_q[i]),
            .d_o (d_lane[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            ready_q <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            q1_q    <= '0;
            p1_q[0] <= '0;
            p1_q[1] <= '0;
            x_mid_q <= '0;
        end else begin
            ready_q <= enable;
            if (enable) begin
                v1_q <= xfer;
                if (xfer) begin
                    q1_q    <= bus.Q_processed_2;
                    p1_q[0] <= p_new[0];
                    p1_q[1] <= p_new[1];
                end
                v2_q <= v1_q;
                if (v1_q) begin
                    x_mid_q <= lane_pack(d_lane[1], d_lane[0]);
                end
            end
        end
    end

    // A result held through a stall is only announced once enable returns, so it is
    // presented exactly once.
    assign bus.accept_out = v2_q & enable;
    assign bus.ready_out  = ready_q;
    assign bus.X_mid_pre  = x_mid_q;

endmodule

// File: tb/tb_midprocess_zf.sv
// Directed bench for midprocess_zf: nominal, saturation, identity, bubbles, stall and
// mid-operation reset, each cycle checked against hand-computed values.
module tb_midprocess_zf;

    logic clk;
    logic reset_n;
    logic enable;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    midprocess_zf_if bus ();

    midprocess_zf dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Operand triples {Q, R, X}
    localparam logic [31:0] D1_Q = 32'h3333_1CCC, D1_R = 32'h0999_0666, D1_X = 32'h0666_0E66;
    localparam logic [31:0] D2_Q = 32'h7FFF_8000, D2_R = 32'h8000_7FFF, D2_X = 32'h7FFF_7FFF;
    localparam logic [31:0] D3_Q = 32'h1234_5678, D3_R = 32'h0000_0000, D3_X = 32'h7FFF_7FFF;
    localparam logic [31:0] D4_Q = 32'h0000_0000, D4_R = 32'hF000_F000, D4_X = 32'h1000_1000;
    localparam logic [31:0] D5_Q = 32'h0800_0400, D5_R = 32'h1000_1000, D5_X = 32'h0500_0200;
    localparam logic [31:0] D6_Q = 32'h0000_FFFF, D6_R = 32'h2000_2000, D6_X = 32'h0100_0300;
    localparam logic [31:0] D7_Q = 32'h0010_0010, D7_R = 32'h0800_0800, D7_X = 32'h0003_FFFD;
    localparam logic [31:0] D8_Q = 32'h7000_4000, D8_R = 32'h4000_4000, D8_X = 32'h3000_D000;

    localparam logic [31:0] E1 = 32'h2F5D_170A;
    localparam logic [31:0] E2 = 32'h7FFF_8000;
    localparam logic [31:0] E3 = 32'h1234_5678;
    localparam logic [31:0] E4 = 32'h1000_1000;
    localparam logic [31:0] E5 = 32'h0300_0200;
    localparam logic [31:0] E6 = 32'hFE00_F9FF;
    localparam logic [31:0] E7 = 32'h000F_0012;
    localparam logic [31:0] E8 = 32'hB000_7FFF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic ao, input logic rdy,
                              input logic [31:0] xm);
        check({tag, "_accept_out"}, 32'(bus.accept_out), 32'(ao));
        check({tag, "_ready_out"},  32'(bus.ready_out),  32'(rdy));
        check({tag, "_x_mid_pre"},  bus.X_mid_pre,       xm);
    endtask

    // Advance to the next cycle, apply that cycle's inputs, let outputs settle.
    task automatic cyc(input logic rst, input logic en, input logic ai,
                       input logic [31:0] q, input logic [31:0] r, input logic [31:0] x);
        @(posedge clk);
        #1;
        reset_n           = rst;
        enable            = en;
        bus.accept_in     = ai;
        bus.Q_processed_2 = q;
        bus.R             = r;
        bus.X_pre         = x;
        #1;
    endtask

    initial begin
        reset_n           = 1'b1;
        enable            = 1'b1;
        bus.accept_in     = 1'b0;
        bus.Q_processed_2 = '0;
        bus.R             = '0;
        bus.X_pre         = '0;

        cyc(1, 1, 0, 32'h0, 32'h0, 32'h0);
        cyc(1, 1, 1, D1_Q, D1_R, D1_X);
        expect_out("reset", 0, 0, 32'h0);

        cyc(0, 1, 0, 32'h0, 32'h0, 32'h0);
        expect_out("release", 0, 0, 32'h0);
        cyc(0, 1, 1, D1_Q, D1_R, D1_X);
        expect_out("first_xfer", 0, 1, 32'h0);
        cyc(0, 1, 1, D2_Q, D2_R, D2_X);
        expect_out("lat1", 0, 1, 32'h0);
        cyc(0, 1, 1, D3_Q, D3_R, D3_X);
        expect_out("nominal", 1, 1, E1);
        cyc(0, 1, 1, D4_Q, D4_R, D4_X);
        expect_out("saturate", 1, 1, E2);
        cyc(0, 1, 0, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222);
        expect_out("identity", 1, 1, E3);
        cyc(0, 1, 1, D5_Q, D5_R, D5_X);
        expect_out("neg_operands", 1, 1, E4);
        cyc(0, 1, 1, D6_Q, D6_R, D6_X);
        expect_out("bubble", 0, 1, E4);
        cyc(0, 1, 1, D7_Q, D7_R, D7_X);
        expect_out("after_bubble", 1, 1, E5);

        // Stall for three cycles with changing operands and accept_in mostly high
        cyc(0, 0, 1, 32'h0101_0202, 32'h1000_1000, 32'h0303_0404);
        expect_out("stall1", 0, 1, E6);
        cyc(0, 0, 1, 32'h0505_0606, 32'h2000_2000, 32'h0707_0808);
        expect_out("stall2", 0, 0, E6);
        cyc(0, 0, 0, 32'h0909_0A0A, 32'h3000_3000, 32'h0B0B_0C0C);
        expect_out("stall3", 0, 0, E6);
        cyc(0, 1, 1, D8_Q, D8_R, D8_X);
        expect_out("resume_held", 1, 0, E6);
        cyc(0, 1, 1, D8_Q, D8_R, D8_X);
        expect_out("resume_pending", 1, 1, E7);
        cyc(0, 1, 0, 32'h0, 32'h0, 32'h0);
        expect_out("resume_gap", 0, 1, E7);
        cyc(0, 1, 1, D1_Q, D1_R, D1_X);
        expect_out("resume_new", 1, 1, E8);
        cyc(0, 1, 1, D2_Q, D2_R, D2_X);
        expect_out("fill", 0, 1, E8);

        // Reset with results in both stages
        cyc(1, 1, 1, D3_Q, D3_R, D3_X);
        expect_out("pre_reset", 1, 1, E1);
        cyc(0, 1, 1, D4_Q, D4_R, D4_X);
        expect_out("mid_reset", 0, 0, 32'h0);
        cyc(0, 1, 0, 32'h0, 32'h0, 32'h0);
        expect_out("post_reset1", 0, 1, 32'h0);
        cyc(0, 1, 0, 32'h0, 32'h0, 32'h0);
        expect_out("post_reset2", 0, 1, 32'h0);
        cyc(0, 1, 0, 32'h0, 32'h0, 32'h0);
        expect_out("post_reset3", 0, 1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
